// File: rtl/mat_unit_stream_pkg.sv
// Shared types and defaults for the streaming systolic matrix unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mat_unit_stream_pkg;

    localparam int MAT_N_DEFAULT = 4;

    // Controller states; the top keeps them as plain 2-bit constants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } mat_state_t;

    // One row/column vector of the default-sized array.
    typedef shortreal mat_vec_t [MAT_N_DEFAULT];

endpackage

// File: rtl/mat_unit_stream_if.sv
// Bundle of the matrix unit's streaming, weight-load and status signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready from slave to master; result stream has none.
// Modports: master drives in_valid/data_in/w_valid/w_row/w_data/w_swap and observes
//   in_ready/out_valid/data_out/busy; slave (the unit) is the mirror image.
interface mat_unit_stream_if #(
    parameter int N = 4
);
    logic                 in_valid;
    logic                 in_ready;
    shortreal             data_in  [N];
    logic                 w_valid;
    logic [$clog2(N)-1:0] w_row;
    shortreal             w_data   [N];
    logic                 w_swap;
    logic                 out_valid;
    shortreal             data_out [N];
    logic                 busy;

    modport master (
        output in_valid, data_in, w_valid, w_row, w_data, w_swap,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, w_valid, w_row, w_data, w_swap,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/mat_unit_stream_pe.sv
// One weight-stationary processing element: psum_out = psum_in + x*w, x forwarded east.
// Latency: 1 cycle on both the x and the partial-sum path.
// Backpressure: none; advances every cycle.
// Ports: clock, reset (sync, active-high); w_load/w_in load the active weight;
//   x_in/x_out horizontal operand, psum_in/psum_out vertical partial sum.
module mat_unit_stream_pe (
    input  logic     clock,
    input  logic     reset,
    input  logic     w_load,
    input  shortreal w_in,
    input  shortreal x_in,
    input  shortreal psum_in,
    output shortreal x_out,
    output shortreal psum_out
);
    shortreal w;

    always_ff @(posedge clock) begin
        if (reset) begin
            w        <= 0.0;
            x_out    <= 0.0;
            psum_out <= 0.0;
        end else begin
            if (w_load) begin
                w <= w_in;
            end
            x_out    <= x_in;
            psum_out <= psum_in + x_in * w;
        end
    end
endmodule

// File: rtl/mat_unit_stream.sv
// N x N weight-stationary shortreal matrix unit: data_out[j] = sum_i data_in[i]*W[i][j].
// Latency: exactly 2*N cycles accept -> out_valid, one vector per cycle.
// Backpressure: in_ready low while w_swap is high and while a swap drains/executes; no output stall.
// Ports: clock, reset (sync, active-high); bus = mat_unit_stream_if.slave (input stream,
//   shadow-row writes, swap command, result stream, busy).
// Build option: MAT_UNIT_RELU_EN clamps negative results to 0.0 at the output stage.
module mat_unit_stream
    import mat_unit_stream_pkg::*;
#(
    parameter int N = MAT_N_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    mat_unit_stream_if.slave  bus
);
    localparam int CW = $clog2(2*N+1);
    localparam int RW = $clog2(N);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_SWAP  = SWAP;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2*N:0]  vld;
    logic          accept;
    logic          out_vld;
    logic          w_load;

    shortreal shadow [N][N];
    shortreal w_next [N][N];
    shortreal x_h    [N][N+1];   // x entering PE[i][j] is x_h[i][j]
    shortreal psum_v [N+1][N];   // partial sum entering PE[i][j] is psum_v[i][j]

    // ---------------- control ----------------
    assign bus.in_ready = ((state == S_IDLE) || (state == S_RUN)) && !bus.w_swap;
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_vld      = vld[2*N];
    assign bus.out_valid = out_vld;
    assign bus.busy     = (state != S_IDLE) || (cnt != '0);
    assign w_load       = (state == S_SWAP);

    always_comb begin
        cnt_nxt = cnt;
        if (accept && !out_vld) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!accept && out_vld) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // Transitions look at the post-edge count so RUN/DRAIN leave on the same
    // edge that retires the last in-flight vector.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.w_swap) state_nxt = S_SWAP;
                     else if (accept) state_nxt = S_RUN;
            S_RUN:   if (bus.w_swap) state_nxt = S_DRAIN;
                     else if (cnt_nxt == '0) state_nxt = S_IDLE;
            S_DRAIN: if (cnt_nxt == '0) state_nxt = S_SWAP;
            S_SWAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            vld   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            vld   <= {vld[2*N-1:0], accept};
        end
    end

    // ---------------- weight banks ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    shadow[i][j] <= 0.0;
                end
            end
        end else if (bus.w_valid) begin
            for (int j = 0; j < N; j++) begin
                shadow[bus.w_row][j] <= bus.w_data[j];
            end
        end
    end

    // A row written in the copy cycle itself is forwarded, so the copy always
    // sees the newest shadow contents.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_next[i][j] = (bus.w_valid && (bus.w_row == RW'(i))) ? bus.w_data[j]
                                                                       : shadow[i][j];
            end
        end
    end

    // ---------------- input skew: row i delayed i+1 cycles ----------------
    for (genvar i = 0; i < N; i++) begin : g_skew
        shortreal sk [i+1];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < i + 1; k++) begin
                    sk[k] <= 0.0;
                end
            end else begin
                sk[0] <= accept ? bus.data_in[i] : 0.0;
                for (int k = 1; k < i + 1; k++) begin
                    sk[k] <= sk[k-1];
                end
            end
        end

        assign x_h[i][0] = sk[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_top
        assign psum_v[0][j] = 0.0;
    end

    // ---------------- PE array ----------------
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            mat_unit_stream_pe u_pe (
                .clock    (clock),
                .reset    (reset),
                .w_load   (w_load),
                .w_in     (w_next[i][j]),
                .x_in     (x_h[i][j]),
                .psum_in  (psum_v[i][j]),
                .x_out    (x_h[i][j+1]),
                .psum_out (psum_v[i+1][j])
            );
        end
    end

    // ---------------- output de-skew: column j delayed N-j cycles ----------------
    for (genvar j = 0; j < N; j++) begin : g_deskew
        shortreal ds [N-j];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int k = 0; k < N - j; k++) begin
                    ds[k] <= 0.0;
                end
            end else begin
                ds[0] <= psum_v[N][j];
                for (int k = 1; k < N - j; k++) begin
                    ds[k] <= ds[k-1];
                end
            end
        end

`ifdef MAT_UNIT_RELU_EN
        assign bus.data_out[j] = (ds[N-j-1] < 0.0) ? 0.0 : ds[N-j-1];
`else
        assign bus.data_out[j] = ds[N-j-1];
`endif
    end

endmodule

// File: tb/tb_mat_unit_stream.sv
// Randomized + directed bench for mat_unit_stream against a cycle-level reference model.
// Latency: model expects results 2*N edges after the accepting edge.
// Backpressure: model predicts in_ready from pending swap requests and in-flight vectors.
module tb_mat_unit_stream;
    import mat_unit_stream_pkg::*;

    localparam int N   = MAT_N_DEFAULT;
    localparam int RW  = $clog2(N);
    localparam int LAT = 2 * N;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mat_unit_stream_if #(.N(N)) bus ();

    mat_unit_stream #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state
    shortreal act [N][N];      // weights used by newly accepted vectors
    shortreal sh  [N][N];      // shadow bank
    int       due_q [$];       // edge number at which each pending result appears
    shortreal res_q [$];       // N expected values per pending result
    int       mode   = 0;      // 0: free, 1: swap waiting for drain, 2: bank copy cycle
    int       edge_n = 0;
    mat_vec_t drv_x;
    mat_vec_t drv_w;
    int       obs_edge = -1;
    int       acc_edge = 0;
    shortreal obs_v [N];
    int       rv;

    task automatic check(input string tag, input real got, input real exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %g expected %g (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic tick(input bit iv, input bit wv, input int wrow, input bit ws);
        bit       exp_rdy;
        bit       exp_ov;
        int       pend;
        shortreal s;
        @(negedge clock);
        bus.in_valid = iv;
        bus.w_valid  = wv;
        bus.w_row    = RW'(wrow);
        bus.w_swap   = ws;
        for (int j = 0; j < N; j++) begin
            bus.data_in[j] = drv_x[j];
            bus.w_data[j]  = drv_w[j];
        end
        #1;
        pend    = due_q.size();
        exp_rdy = (mode == 0) && !ws;
        exp_ov  = (pend != 0) && (due_q[0] == edge_n);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, exp_ov);
        check("busy", bus.busy, (mode != 0) || (pend != 0));
        if (bus.out_valid) begin
            obs_edge = edge_n;
            for (int j = 0; j < N; j++) obs_v[j] = bus.data_out[j];
        end
        if (exp_ov) begin
            for (int j = 0; j < N; j++)
                check($sformatf("data_out[%0d]", j), bus.data_out[j], res_q[j]);
            void'(due_q.pop_front());
            for (int j = 0; j < N; j++) void'(res_q.pop_front());
        end
        if (wv) begin
            for (int j = 0; j < N; j++) sh[wrow][j] = drv_w[j];
        end
        if (iv && exp_rdy) begin
            acc_edge = edge_n + 1;
            for (int j = 0; j < N; j++) begin
                s = 0.0;
                for (int i = 0; i < N; i++) s = s + drv_x[i] * act[i][j];
`ifdef MAT_UNIT_RELU_EN
                if (s < 0.0) s = 0.0;
`endif
                res_q.push_back(s);
            end
            due_q.push_back(edge_n + 1 + LAT);
        end
        case (mode)
            0:       if (ws) mode = (pend != 0) ? 1 : 2;
            1:       if (due_q.size() == 0) mode = 2;
            default: begin act = sh; mode = 0; end
        endcase
        edge_n++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
        bus.w_swap   = 1'b0;
        bus.w_row    = '0;
        for (int j = 0; j < N; j++) begin
            bus.data_in[j] = 0.0;
            bus.w_data[j]  = 0.0;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        due_q.delete();
        res_q.delete();
        mode   = 0;
        edge_n = edge_n + 2;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                act[i][j] = 0.0;
                sh[i][j]  = 0.0;
            end
        #1;
        check("rst_in_ready", bus.in_ready, 1.0);
        check("rst_out_valid", bus.out_valid, 0.0);
        check("rst_busy", bus.busy, 0.0);
        for (int j = 0; j < N; j++)
            check($sformatf("rst_data_out[%0d]", j), bus.data_out[j], 0.0);
    endtask

    task automatic set_x(input shortreal a, input shortreal b, input shortreal c, input shortreal d);
        drv_x[0] = a; drv_x[1] = b; drv_x[2] = c; drv_x[3] = d;
    endtask

    task automatic load_row(input int r, input shortreal a, input shortreal b,
                            input shortreal c, input shortreal d);
        drv_w[0] = a; drv_w[1] = b; drv_w[2] = c; drv_w[3] = d;
        tick(1'b0, 1'b1, r, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int j = 0; j < N; j++) begin
            drv_x[j] = 0.0;
            drv_w[j] = 0.0;
            obs_v[j] = 0.0;
        end
        do_reset();

        // Identity weights: result equals input, exactly LAT cycles later.
        load_row(0, 1, 0, 0, 0);
        load_row(1, 0, 1, 0, 0);
        load_row(2, 0, 0, 1, 0);
        load_row(3, 0, 0, 0, 1);
        tick(1'b0, 1'b0, 0, 1'b1);
        idle(1);
        obs_edge = -1;
        set_x(1, 2, 3, 4);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(LAT + 2);
        check("id_latency", obs_edge - acc_edge, LAT);
        for (int j = 0; j < N; j++) check($sformatf("id_out[%0d]", j), obs_v[j], j + 1);

        // All-ones weights, three back-to-back vectors.
        for (int r = 0; r < N; r++) load_row(r, 1, 1, 1, 1);
        tick(1'b0, 1'b0, 0, 1'b1);
        idle(1);
        set_x(1, 1, 1, 1); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(5, 5, 5, 5); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(0, 2, 0, 1); tick(1'b1, 1'b0, 0, 1'b0);
        idle(LAT + 2);
        check("ones_last", obs_v[0], 3.0);
        check("ones_latency", obs_edge - acc_edge, LAT);

        // Shadow gets 2*I while active stays all-ones; swap requested mid-stream.
        for (int r = 0; r < N; r++) begin
            drv_w[0] = 0; drv_w[1] = 0; drv_w[2] = 0; drv_w[3] = 0;
            drv_w[r] = 2;
            tick(1'b0, 1'b1, r, 1'b0);
        end
        set_x(1, 0, 0, 0); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(0, 3, 0, 0); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(1, 1, 2, 2); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(4, 4, 4, 4); tick(1'b1, 1'b0, 0, 1'b1);
        for (int k = 0; k < LAT + 4; k++) begin
            set_x(k, 1, -k, 2);
            tick(1'b1, 1'b0, 0, 1'b0);
        end
        set_x(1, 2, 3, 4); tick(1'b1, 1'b0, 0, 1'b0);
        idle(LAT + 2);
        check("swap_new_w", obs_v[3], 8.0);

        // Row write and swap in the same IDLE cycle.
        drv_w[0] = 7; drv_w[1] = 7; drv_w[2] = 7; drv_w[3] = 7;
        tick(1'b0, 1'b1, 2, 1'b1);
        idle(1);
        set_x(0, 0, 1, 0); tick(1'b1, 1'b0, 0, 1'b0);
        idle(LAT + 2);
        for (int j = 0; j < N; j++) check($sformatf("wswap_out[%0d]", j), obs_v[j], 7.0);

        // Reset with two vectors in flight: nothing must emerge.
        set_x(1, 1, 1, 1); tick(1'b1, 1'b0, 0, 1'b0);
        set_x(2, 2, 2, 2); tick(1'b1, 1'b0, 0, 1'b0);
        do_reset();
        obs_edge = -1;
        idle(10);
        check("rst_drop", obs_edge, -1);

        // Negated identity.
        load_row(0, -1, 0, 0, 0);
        load_row(1, 0, -1, 0, 0);
        load_row(2, 0, 0, -1, 0);
        load_row(3, 0, 0, 0, -1);
        tick(1'b0, 1'b0, 0, 1'b1);
        idle(1);
        set_x(1, -2, 3, -4);
        tick(1'b1, 1'b0, 0, 1'b0);
        idle(LAT + 2);
`ifdef MAT_UNIT_RELU_EN
        check("negi_out[0]", obs_v[0], 0.0);
        check("negi_out[1]", obs_v[1], 2.0);
        check("negi_out[2]", obs_v[2], 0.0);
        check("negi_out[3]", obs_v[3], 4.0);
`else
        check("negi_out[0]", obs_v[0], -1.0);
        check("negi_out[1]", obs_v[1], 2.0);
        check("negi_out[2]", obs_v[2], -3.0);
        check("negi_out[3]", obs_v[3], 4.0);
`endif

        // Random traffic: streams, row writes and swaps in any state.
        for (int t = 0; t < 500; t++) begin
            for (int j = 0; j < N; j++) begin
                rv = int'($urandom_range(8)) - 4;
                drv_x[j] = rv;
                rv = int'($urandom_range(6)) - 3;
                drv_w[j] = rv;
            end
            tick($urandom_range(9) < 7, $urandom_range(4) == 0,
                 int'($urandom_range(N - 1)), $urandom_range(24) == 0);
        end
        idle(2 * LAT + 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
